// File: rtl/serial_tx_pkg.sv
// State codes for serial_pattern_tx. Kept in a package so that detector
// benches can decode the debug state port with the same names.
package serial_tx_pkg;

   localparam int STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_IDLE  = 2'b00;
   localparam logic [STATE_W-1:0] ST_SHIFT = 2'b01;
   localparam logic [STATE_W-1:0] ST_GAP   = 2'b10;
   localparam logic [STATE_W-1:0] ST_DONE  = 2'b11;

   typedef enum logic [STATE_W-1:0] {
      IDLE   = ST_IDLE,
      SHIFT  = ST_SHIFT,
      GAP_S  = ST_GAP,
      DONE_S = ST_DONE
   } state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out register that shifts left and exposes its MSB.
// A load overrides a shift requested in the same cycle.
module piso_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_msb
);

   logic [WIDTH-1:0] r_sreg;

   always_ff @(posedge clk) begin
      if (reset)        r_sreg <= '0;
      else if (i_load)  r_sreg <= i_data;
      else if (i_shift) r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
   end

   assign o_msb = r_sreg[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Sends a captured WIDTH-bit pattern MSB-first, repeat_n times, with GAP idle
// cycles between repetitions and a done pulse at the end.
module serial_pattern_tx
   import serial_tx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4,
   parameter int GAP   = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   pattern,
   input  logic [CNT_W-1:0]   repeat_n,
   output logic               ready,
   output logic               x,
   output logic               x_valid,
   output logic               done,
   output logic [STATE_W-1:0] state
);

   localparam int BIT_W = $clog2(WIDTH);
   localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

   state_e           r_state;
   logic [WIDTH-1:0] r_hold;
   logic [BIT_W-1:0] r_bit_cnt;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [CNT_W-1:0] r_rep_cnt;
   logic             r_ready;
   logic             r_x;
   logic             r_x_valid;
   logic             r_done;

   logic             w_capture;
   logic             w_last_bit;
   logic             w_reload;
   logic             w_load;
   logic             w_shift;
   logic             w_msb;
   logic [WIDTH-1:0] w_load_data;

   always_comb begin
      w_capture   = (r_state == IDLE) && r_ready && start;
      w_last_bit  = (r_state == SHIFT) && (r_bit_cnt == '0);
      w_reload    = (w_last_bit && (r_rep_cnt != CNT_W'(1)) && (GAP == 0)) ||
                    ((r_state == GAP_S) && (r_gap_cnt == '0));
      w_load      = w_capture || w_reload;
      w_shift     = (r_state == SHIFT);
      w_load_data = w_capture ? pattern : r_hold;
   end

   piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (w_load_data),
      .o_msb   (w_msb)
   );

   // Outputs are registered from the current state, so they trail r_state by
   // one cycle; ready additionally waits one IDLE cycle after done.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the hold register is cleared too, so a reset mid-frame leaves no stale pattern behind.
         r_state   <= IDLE;
         r_hold    <= '0;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
         r_rep_cnt <= '0;
         r_ready   <= 1'b1;
         r_x       <= 1'b0;
         r_x_valid <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_x_valid <= (r_state == SHIFT);
         r_x       <= (r_state == SHIFT) && w_msb;
         r_done    <= (r_state == DONE_S);
         r_ready   <= (r_state == IDLE) && !w_capture;

         case (r_state)
            IDLE: begin
               if (w_capture) begin
                  r_hold    <= pattern;
                  r_rep_cnt <= repeat_n;
                  r_bit_cnt <= BIT_W'(WIDTH - 1);
                  r_state   <= (repeat_n != '0) ? SHIFT : DONE_S;
               end
            end
            SHIFT: begin
               if (r_bit_cnt != '0) begin
                  r_bit_cnt <= r_bit_cnt - 1'b1;
               end else begin
                  r_rep_cnt <= r_rep_cnt - 1'b1;
                  if (r_rep_cnt == CNT_W'(1)) begin
                     r_state <= DONE_S;
                  end else if (GAP > 0) begin
                     r_gap_cnt <= GAP_W'(GAP - 1);
                     r_state   <= GAP_S;
                  end else begin
                     r_bit_cnt <= BIT_W'(WIDTH - 1);
                  end
               end
            end
            GAP_S: begin
               if (r_gap_cnt == '0) begin
                  r_bit_cnt <= BIT_W'(WIDTH - 1);
                  r_state   <= SHIFT;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 1'b1;
               end
            end
            DONE_S:  r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ready   = r_ready;
   assign x       = r_x;
   assign x_valid = r_x_valid;
   assign done    = r_done;
   assign state   = r_state;

endmodule
